// File: rtl/param_dual_port_ram.sv
// Parameterised true dual-port RAM with a power-up clear sweep.
// After reset the array is swept once, writing INIT_VAL to every word, and
// only then are port requests accepted (ready=1). Port 1 wins a same-address
// dual write, which is flagged on coll for one cycle. RDW_MODE selects whether
// a cross-port read of a word being written returns the old or the new word.
module param_dual_port_ram #(
  parameter int unsigned        DATA_W   = 8,
  parameter int unsigned        ADDR_W   = 4,
  parameter int unsigned        RDW_MODE = 0,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en1,
  input  logic              en2,
  input  logic              wr1,
  input  logic              wr2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic              vld1,
  output logic              vld2,
  output logic              ready,
  output logic              coll
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              running;
  logic              rd1;
  logic              rd2;
  logic              we1;
  logic              we2;
  logic              we2_eff;
  logic              same_addr;
  logic              dual_write_hit;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  // Decode port requests; nothing is honoured until the sweep has finished,
  // and port 2's write is dropped when port 1 writes the same word.
  always_comb begin
    running        = (state == RUN);
    same_addr      = (addr1 == addr2);
    rd1            = running & en1 & ~wr1;
    rd2            = running & en2 & ~wr2;
    we1            = running & en1 & wr1;
    we2            = running & en2 & wr2;
    dual_write_hit = we1 & we2 & same_addr;
    we2_eff        = we2 & ~dual_write_hit;
  end

  // Select read data, bypassing the other port's write data in new-data mode.
  always_comb begin
    rd_data1 = mem[addr1];
    rd_data2 = mem[addr2];
    if (RDW_MODE != 0) begin
      if (we2_eff && same_addr) begin
        rd_data1 = data_in2;
      end
      if (we1 && same_addr) begin
        rd_data2 = data_in1;
      end
    end
  end

  // Storage array: the clear sweep owns it in CLEAR, the two ports in RUN.
  // It needs no reset; reset forces CLEAR, which blocks all port writes.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= INIT_VAL;
    end else begin
      if (we1) begin
        mem[addr1] <= data_in1;
      end
      if (we2_eff) begin
        mem[addr2] <= data_in2;
      end
    end
  end

  // Control FSM, sweep pointer and registered port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      ptr       <= '0;
      ready     <= 1'b0;
      coll      <= 1'b0;
      vld1      <= 1'b0;
      vld2      <= 1'b0;
      data_out1 <= '0;
      data_out2 <= '0;
    end else begin
      vld1 <= rd1;
      vld2 <= rd2;
      coll <= dual_write_hit;
      if (rd1) begin
        data_out1 <= rd_data1;
      end
      if (rd2) begin
        data_out2 <= rd_data2;
      end
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_ADDR) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: doc/param_dual_port_ram.md
PARAM_DUAL_PORT_RAM -- requirements
Module: param_dual_port_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits (1..64).
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter RDW_MODE, default 0, cross-port read-during-write result (0 = old data, 1 = new data).
REQ-004 SHALL have parameter INIT_VAL, default 0, DATA_W-bit value written to every word by the clear sweep.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports en1/en2  input  1  port 1/2 request enable.
REQ-008 SHALL have ports wr1/wr2  input  1  port 1/2 write (1) or read (0); meaningful only with en.
REQ-009 SHALL have ports addr1/addr2  input  ADDR_W  port 1/2 word address.
REQ-010 SHALL have ports data_in1/data_in2  input  DATA_W  port 1/2 write data.
REQ-011 SHALL have ports data_out1/data_out2  output  DATA_W  port 1/2 registered read data.
REQ-012 SHALL have ports vld1/vld2  output  1  port 1/2 read data valid, one-cycle pulse.
REQ-013 SHALL have port ready  output  1  clear sweep complete; requests accepted.
REQ-014 SHALL have port coll  output  1  registered same-address dual-write collision pulse.

Function
REQ-015 SHALL implement a two-state FSM, CLEAR and RUN, plus an ADDR_W-bit clear pointer.
REQ-016 In CLEAR, each rising edge SHALL write INIT_VAL to mem[ptr] and increment ptr.
REQ-017 CLEAR SHALL move to RUN on the edge that writes mem[DEPTH-1]; ready is registered high on that same edge, i.e. DEPTH edges after rst deasserts.
REQ-018 In CLEAR, all en/wr/addr/data inputs SHALL be ignored; vld1/vld2/coll stay 0 and data_out holds 0.
REQ-019 In RUN, en=1 and wr=1 SHALL write data_in to mem[addr] on the edge; data_out holds and vld stays 0.
REQ-020 In RUN, en=1 and wr=0 SHALL register mem[addr] into data_out on the edge and pulse vld=1 for the following cycle (latency 1).
REQ-021 In RUN, en=0 SHALL leave memory and data_out unchanged; vld=0.
REQ-022 Ports SHALL be fully independent and concurrent; reads by both ports to any addresses, including equal addresses, are both served in the same cycle.
REQ-023 Port-x write and port-y read to the same address on one edge SHALL return the pre-write word when RDW_MODE=0 and the written word when RDW_MODE=1.
REQ-024 Both ports writing the same address on one edge SHALL store data_in1 (port 1 priority) and set coll=1 for exactly the next cycle; otherwise coll=0.
REQ-025 Both ports writing different addresses SHALL update both words; coll=0.
REQ-026 Same-port read of a just-written address on the next edge SHALL return the new word.
REQ-027 Address arithmetic SHALL be modulo DEPTH; ptr wraps only via the state change, never re-sweeping.
REQ-028 ready SHALL stay 1 in RUN until the next rst assertion.

Reset
REQ-029 rst=1 SHALL immediately, without a clock edge, force data_out1=data_out2=0, vld1=vld2=0, ready=0, coll=0, state=CLEAR, ptr=0.
REQ-030 rst asserted mid-RUN or mid-CLEAR SHALL abort any operation and restart a full sweep after release; no port write lands on the edge on which rst is high.
REQ-031 Memory contents SHALL be undefined only until the sweep writes them; after ready=1 every word equals INIT_VAL.

Verification
REQ-032 Reset, then release with default parameters -> ready=0 for 15 edges and 1 after edge 16; reading addr 0..15 gives 0x00 with vld one cycle later.
REQ-033 In CLEAR at edge 5, issue en1=1, wr1=1, addr1=3, data_in1=0xAA -> ignored; after ready, reading addr 3 gives 0x00.
REQ-034 RUN, port1 writes 0x5C to addr 7 while port2 reads addr 7 (word 0x11) -> data_out2=0x11 when RDW_MODE=0 and 0x5C when RDW_MODE=1; vld2=1 next cycle.
REQ-035 RUN, both write addr 9 (0x12 on port 1, 0x34 on port 2) -> coll=1 for one cycle; subsequent read of addr 9 returns 0x12.
REQ-036 Assert rst asynchronously mid-read (between edges) -> data_out, vld and ready drop to 0 at once; a full 16-edge sweep follows release.
REQ-037 Repeat REQ-032 and REQ-035 with DATA_W=32, ADDR_W=6, INIT_VAL=0xDEADBEEF -> ready after 64 edges, all words 0xDEADBEEF, port-1 priority preserved.
